// File: rtl/top_file_controller.sv
// Top-level sequencing FSM for the SAT-solver datapath: one pass per start request,
// stepping through fixed phases and decoding a Moore control bundle from the state.
module top_file_controller #(
  parameter int CONTROLLER_SIGNAL_WIDTH = 14
) (
  input  logic                               clk,
  input  logic                               rst,
  input  logic                               start,
  output logic                               done,
  output logic [CONTROLLER_SIGNAL_WIDTH-1:0] control_signal_o
);

  // Field positions within the control bundle
  localparam int CR_WR_EN_BIT      = 13;
  localparam int ATT_SRC_HI        = 12;
  localparam int ATT_SRC_LO        = 11;
  localparam int VT_ADDR_SRC_BIT   = 10;
  localparam int VT_EN_BIT         = 9;
  localparam int VT_WR_EN_BIT      = 8;
  localparam int VFS_WR_EN_HI      = 7;
  localparam int VFS_WR_EN_LO      = 6;
  localparam int CFLB_WR_EN_BIT    = 5;
  localparam int TB_WR_INDEX_HI    = 4;
  localparam int TB_WR_INDEX_LO    = 3;
  localparam int FIFO_WR_EN_BIT    = 2;
  localparam int FIFO_RD_EN_BIT    = 1;
  localparam int UCS_REQUEST_BIT   = 0;

  typedef enum logic [3:0] {
    IDLE                       = 4'd0,
    LOAD                       = 4'd1,
    SELECT_UNSAT_CLAUSES       = 4'd2,
    READ_CLAUSE_TABLE          = 4'd3,
    READ_VARIABLE_TABLE        = 4'd4,
    EVALUATE_CLAUSE            = 4'd5,
    COUNT_UNSAT_CLAUSES        = 4'd6,
    GATHER_UNSAT_CLAUSES       = 4'd7,
    SELECT_UNSAT_CLAUSES_AGAIN = 4'd8,
    DONE                       = 4'd9
  } state_t;

  state_t state_reg;
  state_t state_next;

  logic [CONTROLLER_SIGNAL_WIDTH-1:0] control_next;
  logic                               done_next;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_reg <= IDLE;
    end else begin
      state_reg <= state_next;
    end
  end

  // Outputs depend only on state_reg, so they settle to zero as soon as reset clears it
  always_comb begin
    state_next   = IDLE;
    control_next = '0;
    done_next    = 1'b0;
    case (state_reg)
      IDLE: begin
        state_next = start ? LOAD : IDLE;
      end
      LOAD: begin
        state_next = SELECT_UNSAT_CLAUSES;
      end
      SELECT_UNSAT_CLAUSES: begin
        control_next[CR_WR_EN_BIT]    = 1'b1;
        control_next[UCS_REQUEST_BIT] = 1'b1;
        state_next                    = READ_CLAUSE_TABLE;
      end
      READ_CLAUSE_TABLE: begin
        control_next[ATT_SRC_HI:ATT_SRC_LO]         = 2'b00;
        control_next[TB_WR_INDEX_HI:TB_WR_INDEX_LO] = 2'b00;
        state_next                                  = READ_VARIABLE_TABLE;
      end
      READ_VARIABLE_TABLE: begin
        control_next[VT_EN_BIT]                     = 1'b1;
        control_next[VT_WR_EN_BIT]                  = 1'b0;
        control_next[VT_ADDR_SRC_BIT]               = 1'b0;
        control_next[TB_WR_INDEX_HI:TB_WR_INDEX_LO] = 2'b01;
        state_next                                  = EVALUATE_CLAUSE;
      end
      EVALUATE_CLAUSE: begin
        control_next[VFS_WR_EN_HI:VFS_WR_EN_LO]     = 2'b01;
        control_next[CFLB_WR_EN_BIT]                = 1'b1;
        control_next[TB_WR_INDEX_HI:TB_WR_INDEX_LO] = 2'b10;
        state_next                                  = COUNT_UNSAT_CLAUSES;
      end
      COUNT_UNSAT_CLAUSES: begin
        state_next = GATHER_UNSAT_CLAUSES;
      end
      GATHER_UNSAT_CLAUSES: begin
        control_next[FIFO_WR_EN_BIT] = 1'b1;
        state_next                   = SELECT_UNSAT_CLAUSES_AGAIN;
      end
      SELECT_UNSAT_CLAUSES_AGAIN: begin
        control_next[FIFO_RD_EN_BIT] = 1'b1;
        state_next                   = DONE;
      end
      DONE: begin
        done_next  = 1'b1;
        state_next = IDLE;
      end
      default: begin
        // Unused codes recover to IDLE with everything deasserted
        state_next = IDLE;
      end
    endcase
  end

  assign control_signal_o = control_next;
  assign done             = done_next;

endmodule

// File: tb/tb_top_file_controller.sv
// Self-checking bench for top_file_controller: directed scenarios plus random start/reset
// traffic, compared against a pass-position model and a per-position expected-output table.
module tb_top_file_controller;

  logic        clk;
  logic        rst;
  logic        start;
  logic        done;
  logic [13:0] control_signal_o;

  int checks;
  int errors;
  int pos;      // 0 = idle, 1..9 = cycle index within a pass (9 = done cycle)
  int cyc;

  top_file_controller #(.CONTROLLER_SIGNAL_WIDTH(14)) dut (
    .clk              (clk),
    .rst              (rst),
    .start            (start),
    .done             (done),
    .control_signal_o (control_signal_o)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic logic [13:0] exp_ctrl(input int p);
    case (p)
      2:       return 14'h2001;
      4:       return 14'h0208;
      5:       return 14'h0070;
      7:       return 14'h0004;
      8:       return 14'h0002;
      default: return 14'h0000;
    endcase
  endfunction

  task automatic check(input string tag);
    logic [13:0] ec;
    logic        ed;
    ec = exp_ctrl(pos);
    ed = (pos == 9);
    checks++;
    assert (control_signal_o === ec) else begin
      errors++;
      $error("FAIL %s ctrl cyc=%0d observed=%h expected=%h", tag, cyc, control_signal_o, ec);
    end
    checks++;
    assert (done === ed) else begin
      errors++;
      $error("FAIL %s done cyc=%0d observed=%b expected=%b", tag, cyc, done, ed);
    end
    $display("cyc %0d %s rst=%b start=%b pos=%0d ctrl=%h done=%b",
             cyc, tag, rst, start, pos, control_signal_o, done);
  endtask

  // One clock: drive start, advance model at the edge, check at the falling edge
  task automatic cycle(input logic s, input string tag);
    start = s;
    @(posedge clk);
    if (!rst) pos = 0;
    else if (pos == 0) pos = start ? 1 : 0;
    else if (pos == 9) pos = 0;
    else pos = pos + 1;
    @(negedge clk);
    cyc++;
    check(tag);
  endtask

  // Assert reset between edges and confirm outputs clear before the next rising edge
  task automatic async_reset(input string tag);
    #2 rst = 1'b0;
    #1 pos = 0;
    check(tag);
  endtask

  initial begin
    checks = 0;
    errors = 0;
    pos    = 0;
    cyc    = 0;
    rst    = 1'b0;
    start  = 1'b0;

    @(negedge clk);
    for (int i = 0; i < 5; i++) cycle(1'b0, "reset_hold");
    rst = 1'b1;
    for (int i = 0; i < 3; i++) cycle(1'b0, "idle_after_reset");

    // Single pulse, full pass, then idle
    cycle(1'b1, "pass1");
    for (int i = 0; i < 11; i++) cycle(1'b0, "pass1");

    // Identical second pass
    cycle(1'b1, "pass2");
    for (int i = 0; i < 11; i++) cycle(1'b0, "pass2");

    // Start pulsed while in READ_VARIABLE_TABLE must be ignored
    cycle(1'b1, "mid_start");
    for (int i = 0; i < 11; i++) cycle(pos == 4, "mid_start");

    // Asynchronous reset during EVALUATE_CLAUSE
    cycle(1'b1, "async_rst");
    while (pos != 5) cycle(1'b0, "async_rst");
    async_reset("async_rst_now");
    for (int i = 0; i < 2; i++) cycle(1'b0, "async_rst_hold");
    rst = 1'b1;
    for (int i = 0; i < 4; i++) cycle(1'b0, "async_rst_idle");

    // Start held high: back-to-back passes with a single idle cycle between
    for (int i = 0; i < 30; i++) cycle(1'b1, "start_held");
    for (int i = 0; i < 11; i++) cycle(1'b0, "start_held_drain");

    // Random start and occasional asynchronous reset
    for (int i = 0; i < 300; i++) begin
      if (rst && $urandom_range(0, 39) == 0) begin
        async_reset("rand_rst");
        cycle(1'b0, "rand_rst_hold");
        rst = 1'b1;
      end else begin
        cycle(($urandom_range(0, 3) == 0), "rand");
      end
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
